demux_1to8_tdm: RTL and testbench
=================================

# demux_1to8_tdm

Time-division 1-to-8 demultiplexer that rebuilds an 8-bit word from a serial bit stream produced by our 8-to-1 multiplexers when their select is scanned by a counter. Each accepted input bit is steered to the output slot named by an internal slot counter. The counter scans up (0→7) or down (7→0), matching both sweep directions used on the mux side. A full frame is presented as a registered parallel word with a one-cycle valid pulse. The block sits at the receive end of any link that serialises a byte through the mux.

## Interface
- CH, 8, number of channels/slots; power of two, ≥2
- SEL_W, 3, slot index width; equals log2(CH)

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  din valid this cycle; no bit is accepted when low
- sync  in  1  frame start; qualified by en; the bit on din in this cycle is the first of a frame
- dir  in  1  scan direction, sampled only on an accepted sync; 0 = up (first slot 0), 1 = down (first slot CH-1)
- din  in  1  serial data bit
- sel  out  SEL_W  slot the next accepted bit will be written to
- out  out  CH  last completed frame, bit i = value received in slot i
- out_valid  out  1  one-cycle pulse; out updated this cycle
- busy  out  1  frame in progress
- frame_err  out  1  one-cycle pulse; frame aborted by premature sync

## Operation
- Two states:
  - IDLE: busy=0, sel=0.
  - RECV: busy=1.
- Internal registers:
  - shadow[CH-1:0]
  - cnt (SEL_W+1 bits): bits accepted this frame
  - dir_q: latched direction
- IDLE:
  - en=1 and sync=1: latch dir_q=dir; write din to start slot (0 if up, CH-1 if down); cnt=1; sel = start±1 (+1 up, −1 down); go RECV.
  - en=1 and sync=0: bit is discarded; no state change.
- RECV, en=1, sync=0:
  - shadow[sel] = din; cnt+1; sel advances one slot in the dir_q direction.
- RECV, en=0: hold all state; gaps of any length are allowed.
- Completion: the accepted bit that makes cnt reach CH ends the frame.
  - out is loaded with shadow, with this last bit merged into its slot.
  - out_valid pulses.
  - State returns to IDLE; sel=0; cnt=0.
- Premature sync: RECV with en=1 and sync=1.
  - frame_err pulses; the partial frame is discarded and out is unchanged.
  - The frame restarts exactly as an IDLE sync: new dir latched, this din goes to the start slot, cnt=1.
- shadow is not cleared between frames. Every slot is rewritten before completion, so stale bits never reach out.
- sel arithmetic is modulo 2^SEL_W. Wrap-around cannot occur inside a legal frame.

## Timing
- All outputs are registered and change only on a rising clk edge or on rst_n assertion.
- Reset values, applied immediately on rst_n=0 regardless of clk: out=0, out_valid=0, busy=0, sel=0, frame_err=0, state=IDLE, cnt=0, shadow=0, dir_q=0.
- Reset mid-frame drops the partial frame; out returns to 0.
- Latency: out and out_valid change at the same edge that samples the final bit.
  - Visible one cycle after the last bit is presented.
  - out_valid is high for exactly one cycle; out holds until the next completion.
- Minimum frame: CH consecutive en cycles. Back-to-back frames are allowed: a sync on the cycle after completion is accepted from IDLE with no lost bit.
- Reaction to sync:
  - busy rises the cycle after an accepted sync in IDLE.
  - busy falls the cycle after the completing bit.
  - frame_err coincides with the restarted frame's first-bit edge; busy stays 1.
- Inputs with en=0 are ignored, including sync and dir.

## Test plan
- Reset then up-scan: sync+dir=0 with din per slot 0..7 = 0,1,0,1,0,1,0,1 on 8 consecutive cycles → out=8'hAA, out_valid for exactly one cycle; sel sequence 1..7 then 0; busy 1 for 7 cycles.
- Down-scan: sync+dir=1, din = 1,0,1,0,1,0,1,0 (slots 7..0) → out=8'hAA; sel steps 6,5,…,0.
- Gapped and back-to-back frames:
  - Up frame 8'h5A with en low for 3 cycles after the 2nd and 5th bits → out=8'h5A only after the 8th accepted bit.
  - Immediately followed by a frame 8'hC3 → two out_valid pulses, no bit lost.
- Premature sync: 4 bits of an up frame, then sync with a full up frame 8'h0F → frame_err pulse at restart; out stays at its previous value until out=8'h0F.
- Reset mid-frame: assert rst_n=0 asynchronously (not clk-aligned) after 5 bits → all outputs 0 immediately. After release, a complete 8'hFF frame → out=8'hFF.
- Stray input: en=1, sync=0 bits in IDLE, and sync with en=0 → no busy, no out_valid, sel stays 0.

Source files
------------

// File: rtl/demux_1to8_tdm.sv
// Time-division 1-to-CH demultiplexer: steers accepted serial bits into slots
// chosen by an up/down slot counter and presents each completed frame as a word.
module demux_1to8_tdm #(
    parameter int CH    = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             dir,
    input  logic             din,
    output logic [SEL_W-1:0] sel,
    output logic [CH-1:0]    out,
    output logic             out_valid,
    output logic             busy,
    output logic             frame_err
);

    typedef enum logic {IDLE, RECV} state_t;

    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CH - 1);
    localparam logic [SEL_W:0]   CNT_ONE  = (SEL_W + 1)'(1);
    localparam logic [SEL_W:0]   CNT_FULL = (SEL_W + 1)'(CH);

    state_t           state, state_n;
    logic [SEL_W:0]   cnt, cnt_n;
    logic [SEL_W-1:0] sel_n;
    logic [CH-1:0]    shadow, shadow_n;
    logic [CH-1:0]    out_n;
    logic             dir_q, dir_n;
    logic             valid_n, ferr_n;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sel_n    = sel;
        shadow_n = shadow;
        out_n    = out;
        dir_n    = dir_q;
        valid_n  = 1'b0;
        ferr_n   = 1'b0;
        if (en) begin
            if (sync) begin
                // A sync while receiving aborts the frame and restarts it in place
                ferr_n   = (state == RECV);
                dir_n    = dir;
                shadow_n[dir ? SEL_LAST : '0] = din;
                cnt_n    = CNT_ONE;
                sel_n    = dir ? (SEL_LAST - SEL_ONE) : SEL_ONE;
                state_n  = RECV;
            end else if (state == RECV) begin
                shadow_n[sel] = din;
                cnt_n         = cnt + CNT_ONE;
                if (cnt_n == CNT_FULL) begin
                    out_n   = shadow_n;
                    valid_n = 1'b1;
                    state_n = IDLE;
                    sel_n   = '0;
                    cnt_n   = '0;
                end else begin
                    sel_n = dir_q ? (sel - SEL_ONE) : (sel + SEL_ONE);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sel       <= '0;
            shadow    <= '0;
            out       <= '0;
            dir_q     <= 1'b0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sel       <= sel_n;
            shadow    <= shadow_n;
            out       <= out_n;
            dir_q     <= dir_n;
            out_valid <= valid_n;
            frame_err <= ferr_n;
        end
    end

    assign busy = (state == RECV);

endmodule

// File: tb/tb_demux_1to8_tdm.sv
// Self-checking bench for demux_1to8_tdm: fixed vector tables, directed
// multi-cycle sequences and random traffic against a frame-level model.
module tb_demux_1to8_tdm;

    localparam int CH    = 8;
    localparam int SEL_W = 3;

    logic             clk, rst_n, en, sync, dir, din;
    logic [SEL_W-1:0] sel;
    logic [CH-1:0]    out;
    logic             out_valid, busy, frame_err;

    int n_checks = 0;
    int n_fails  = 0;

    demux_1to8_tdm #(.CH(CH), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .dir(dir), .din(din),
        .sel(sel), .out(out), .out_valid(out_valid), .busy(busy), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-level model: list of bits received so far in the current frame
    bit          m_in_frame;
    bit          m_dir;
    bit          m_bits[$];
    logic [CH-1:0] m_out;
    bit          m_valid, m_ferr;

    function automatic logic [SEL_W-1:0] m_sel();
        int n = m_bits.size();
        if (!m_in_frame) return '0;
        return SEL_W'(m_dir ? (CH - 1 - n) : n);
    endfunction

    task automatic model_reset();
        m_in_frame = 0; m_dir = 0; m_bits.delete();
        m_out = '0; m_valid = 0; m_ferr = 0;
    endtask

    task automatic model_step(input bit e, input bit s, input bit d, input bit b);
        m_valid = 0;
        m_ferr  = 0;
        if (!e) return;
        if (s) begin
            m_ferr     = m_in_frame;
            m_in_frame = 1;
            m_dir      = d;
            m_bits.delete();
            m_bits.push_back(b);
        end else if (m_in_frame) begin
            m_bits.push_back(b);
            if (m_bits.size() == CH) begin
                for (int k = 0; k < CH; k++)
                    m_out[m_dir ? (CH - 1 - k) : k] = m_bits[k];
                m_valid    = 1;
                m_in_frame = 0;
                m_bits.delete();
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("out", 32'(out), 32'(m_out));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_in_frame));
        chk("sel", 32'(sel), 32'(m_sel()));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
    endtask

    // Drive one cycle, advance the model, sample 1ns after the edge
    task automatic apply(input bit e, input bit s, input bit d, input bit b);
        en = e; sync = s; dir = d; din = b;
        @(posedge clk);
        #1;
        model_step(e, s, d, b);
    endtask

    task automatic step(input bit e, input bit s, input bit d, input bit b);
        apply(e, s, d, b);
        check_model();
    endtask

    task automatic send_frame(input logic [CH-1:0] w, input bit d, input int gap_a, input int gap_b);
        for (int k = 0; k < CH; k++) begin
            step(1'b1, k == 0, d, w[d ? (CH - 1 - k) : k]);
            if (k == 1) for (int g = 0; g < gap_a; g++) step(1'b0, 1'b0, 1'b0, 1'b0);
            if (k == 4) for (int g = 0; g < gap_b; g++) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    typedef struct {
        bit e, s, d, b;
        logic [CH-1:0]    x_out;
        bit               x_valid, x_busy;
        logic [SEL_W-1:0] x_sel;
    } vec_t;

    vec_t vecs[$];
    int   pulses;

    initial begin
        rst_n = 1'b0; en = 0; sync = 0; dir = 0; din = 0;
        model_reset();
        #12;
        chk("reset_out", 32'(out), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_sel", 32'(sel), 0);
        chk("reset_valid", 32'(out_valid), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Up-scan 0,1,0,1,... then down-scan 1,0,1,0,... both give 8'hAA
        vecs.push_back('{1,1,0,0, 8'h00,0,1,3'd1});
        for (int k = 1; k < 7; k++)
            vecs.push_back('{1,0,0,k[0], 8'h00,0,1,3'(k + 1)});
        vecs.push_back('{1,0,0,1, 8'hAA,1,0,3'd0});
        vecs.push_back('{0,0,0,0, 8'hAA,0,0,3'd0});
        vecs.push_back('{1,1,1,1, 8'hAA,0,1,3'd6});
        for (int k = 1; k < 7; k++)
            vecs.push_back('{1,0,0,~k[0], 8'hAA,0,1,3'(6 - k)});
        vecs.push_back('{1,0,0,0, 8'hAA,1,0,3'd0});
        vecs.push_back('{0,0,0,0, 8'hAA,0,0,3'd0});
        foreach (vecs[i]) begin
            apply(vecs[i].e, vecs[i].s, vecs[i].d, vecs[i].b);
            chk($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].x_out));
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].x_valid));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].x_busy));
            chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].x_sel));
            chk($sformatf("vec%0d_ferr", i), 32'(frame_err), 0);
        end

        // Gapped frame followed back-to-back by another
        pulses = 0;
        for (int k = 0; k < CH; k++) begin
            step(1'b1, k == 0, 1'b0, 8'h5A >> k);
            pulses += out_valid;
            if (k == 1 || k == 4) for (int g = 0; g < 3; g++) step(0, 0, 0, 0);
        end
        chk("gap_out", 32'(out), 32'h5A);
        for (int k = 0; k < CH; k++) begin
            step(1'b1, k == 0, 1'b0, 8'hC3 >> k);
            pulses += out_valid;
        end
        chk("b2b_out", 32'(out), 32'hC3);
        chk("b2b_pulses", 32'(pulses), 2);

        // Premature sync: 4 bits then a full new frame
        for (int k = 0; k < 4; k++) step(1'b1, k == 0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("premature_ferr", 32'(frame_err), 1);
        chk("premature_busy", 32'(busy), 1);
        chk("premature_hold", 32'(out), 32'hC3);
        for (int k = 1; k < CH; k++) step(1'b1, 1'b0, 1'b0, 8'h0F >> k);
        chk("premature_out", 32'(out), 32'h0F);

        // Stray inputs in IDLE
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("stray_busy", 32'(busy), 0);

        // Asynchronous reset mid-frame
        for (int k = 0; k < 5; k++) step(1'b1, k == 0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_out", 32'(out), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_sel", 32'(sel), 0);
        chk("arst_valid_ferr", 32'({out_valid, frame_err}), 0);
        #3 rst_n = 1'b1;
        send_frame(8'hFF, 1'b0, 0, 0);
        chk("post_reset_out", 32'(out), 32'hFF);

        // Random traffic against the model
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
                 1'($urandom), 1'($urandom));
        for (int i = 0; i < 4; i++)
            send_frame(8'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
